// File: rtl/core_trace_buffer.sv
// Trace capture FIFO for the core's retired-instruction debug outputs.
// Freezes after EBREAK so the final trace survives until drained.
module core_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_ir,
    input  logic [31:0]   in_aluout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_ir,
    output logic [31:0]   out_aluout,
    output logic [15:0]   out_seq,
    output logic [AW:0]   level,
    output logic [15:0]   dropped,
    output logic          frozen
);

    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);

    typedef enum logic {RUN, FROZEN} state_t;

    state_t        state;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ir_mem  [DEPTH];
    logic [31:0]   alu_mem [DEPTH];
    logic [15:0]   seq_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   seq;
    logic          attempt;
    logic          pop;
    logic          push;

    assign attempt = in_valid & enable & (state == RUN);
    assign out_valid = (count != '0);
    assign pop = out_valid & out_ready;
    // A pop in the same cycle frees a slot even when full.
    assign push = attempt & ((count != FULL) | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            seq     <= '0;
            dropped <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]  <= in_pc;
                ir_mem[wr_ptr]  <= in_ir;
                alu_mem[wr_ptr] <= in_aluout;
                seq_mem[wr_ptr] <= seq;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (attempt)
                seq <= seq + 1'b1;
            if (attempt && !push && dropped != 16'hFFFF)
                dropped <= dropped + 1'b1;
            if (attempt && in_ir == EBREAK)
                state <= FROZEN;
        end
    end

    assign out_pc     = out_valid ? pc_mem[rd_ptr]  : '0;
    assign out_ir     = out_valid ? ir_mem[rd_ptr]  : '0;
    assign out_aluout = out_valid ? alu_mem[rd_ptr] : '0;
    assign out_seq    = out_valid ? seq_mem[rd_ptr] : '0;
    assign level      = count;
    assign frozen     = (state == FROZEN);

endmodule

// File: tb/tb_core_trace_buffer.sv
// Scoreboard bench for core_trace_buffer: queue model at posedge,
// monitor comparing DUT head and status at negedge.
module tb_core_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          in_valid = 1'b0;
    logic [31:0]   in_pc = '0;
    logic [31:0]   in_ir = '0;
    logic [31:0]   in_aluout = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_pc;
    logic [31:0]   out_ir;
    logic [31:0]   out_aluout;
    logic [15:0]   out_seq;
    logic [AW:0]   level;
    logic [15:0]   dropped;
    logic          frozen;

    core_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_pc(in_pc), .in_ir(in_ir),
        .in_aluout(in_aluout), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
        .out_aluout(out_aluout), .out_seq(out_seq), .level(level),
        .dropped(dropped), .frozen(frozen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] alu;
        logic [15:0] seq;
    } rec_t;

    rec_t        sb[$];
    int          mlevel = 0;
    logic [15:0] mseq = '0;
    logic [15:0] mdrop = '0;
    bit          mfrozen = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: trace FIFO as a queue plus counters.
    initial begin
        bit pop, attempt;
        forever begin
            @(posedge clk);
            if (reset) begin
                sb.delete();
                mlevel = 0;
                mseq = '0;
                mdrop = '0;
                mfrozen = 1'b0;
            end else begin
                pop = (mlevel != 0) && out_ready;
                attempt = in_valid && enable && !mfrozen;
                if (pop) mlevel--;
                if (attempt) begin
                    if (mlevel < DEPTH) begin
                        sb.push_back('{in_pc, in_ir, in_aluout, mseq});
                        mlevel++;
                    end else if (mdrop != 16'hFFFF) begin
                        mdrop++;
                    end
                    mseq++;
                    if (in_ir == EBREAK) mfrozen = 1'b1;
                end
            end
        end
    end

    // Monitor: compares status every cycle, head record when valid.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            chk("level", 32'(level), 32'(mlevel));
            chk("out_valid", 32'(out_valid), 32'(mlevel != 0));
            chk("dropped", 32'(dropped), 32'(mdrop));
            chk("frozen", 32'(frozen), 32'(mfrozen));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb[0];
                    chk("out_pc", out_pc, e.pc);
                    chk("out_ir", out_ir, e.ir);
                    chk("out_alu", out_aluout, e.alu);
                    chk("out_seq", 32'(out_seq), 32'(e.seq));
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                chk("empty_pc", out_pc, 32'd0);
                chk("empty_seq", 32'(out_seq), 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        do r = $urandom; while (r == EBREAK);
        return r;
    endfunction

    task automatic push(input logic [31:0] pc, input logic [31:0] ir);
        in_valid = 1'b1;
        in_pc = pc;
        in_ir = ir;
        in_aluout = $urandom;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && level != 0; i++) cyc();
        out_ready = 1'b0;
        chk("drain_done", 32'(level), 32'd0);
    endtask

    initial begin
        cyc();
        do_reset();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);

        // Basic push then drain
        push(32'h0, 32'h00500093);
        push(32'h4, 32'h00a00113);
        push(32'h8, 32'h002081b3);
        chk("t1_level", 32'(level), 32'd3);
        chk("t1_pc", out_pc, 32'h0);
        chk("t1_seq", 32'(out_seq), 32'd0);
        drain();
        chk("t1_empty", 32'(out_valid), 32'd0);

        // Overflow drops
        do_reset();
        for (int i = 0; i < 18; i++) push(32'(i * 4), rand_ir());
        chk("t2_level", 32'(level), 32'd16);
        chk("t2_drop", 32'(dropped), 32'd2);
        drain();
        push(32'h100, rand_ir());
        chk("t2_seq18", 32'(out_seq), 32'd18);
        drain();

        // Push and pop together when full
        do_reset();
        for (int i = 0; i < 16; i++) push(32'(i * 4), rand_ir());
        out_ready = 1'b1;
        push(32'hABC0, rand_ir());
        out_ready = 1'b0;
        chk("t3_level", 32'(level), 32'd16);
        chk("t3_drop", 32'(dropped), 32'd0);
        drain();

        // EBREAK freeze
        do_reset();
        for (int i = 0; i < 8; i++) push(32'(i * 4), rand_ir());
        push(32'h20, EBREAK);
        chk("t4_frozen", 32'(frozen), 32'd1);
        for (int i = 0; i < 5; i++) push(32'(32'h24 + i * 4), rand_ir());
        chk("t4_level", 32'(level), 32'd9);
        chk("t4_drop", 32'(dropped), 32'd0);
        drain();
        chk("t4_still", 32'(frozen), 32'd1);

        // Reset mid-operation wins
        do_reset();
        for (int i = 0; i < 5; i++) push(32'(i * 4), rand_ir());
        reset = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_drop", 32'(dropped), 32'd0);
        chk("t5_frozen", 32'(frozen), 32'd0);
        chk("t5_seq", 32'(out_seq), 32'd0);
        push(32'h40, rand_ir());
        chk("t5_seq0", 32'(out_seq), 32'd0);
        drain();

        // Saturating drop counter and seq wrap
        do_reset();
        in_valid = 1'b1;
        in_ir = 32'h00000013;
        for (int i = 0; i < 16 + 70000; i++) begin
            in_pc = 32'(i);
            cyc();
        end
        in_valid = 1'b0;
        chk("t6_drop", 32'(dropped), 32'h0000FFFF);
        drain();
        push(32'h80, rand_ir());
        chk("t6_seq", 32'(out_seq), 32'd4480);
        drain();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            enable = ($urandom_range(0, 9) != 0);
            in_valid = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 2) != 0);
            in_pc = $urandom;
            in_ir = ($urandom_range(0, 59) == 0) ? EBREAK : rand_ir();
            in_aluout = $urandom;
            cyc();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        enable = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
